// File: rtl/rat_ctrl.sv
// rat_ctrl: front-end controller for the dual-read/single-write RAT SRAM.
// Clears the array after reset and on flush, blocks rename traffic while
// clearing, and forwards same-cycle write data to colliding reads because
// the SRAM returns the pre-write value for those.
module rat_ctrl #(
    parameter int unsigned            ADDRW  = 5,
    parameter int unsigned            DATAW  = 1,
    parameter logic [DATAW-1:0]       CLRVAL = '0
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             flush_req,
    output logic             busy,

    input  logic             rd_req1,
    input  logic [ADDRW-1:0] rd_addr1,
    output logic             rd_valid1,
    output logic [DATAW-1:0] rd_data1,

    input  logic             rd_req2,
    input  logic [ADDRW-1:0] rd_addr2,
    output logic             rd_valid2,
    output logic [DATAW-1:0] rd_data2,

    input  logic             wr_req,
    input  logic [ADDRW-1:0] wr_addr,
    input  logic [DATAW-1:0] wr_data,
    output logic             ready,

    output logic             sram_rd_en1,
    output logic [ADDRW-1:0] sram_rd_addr1,
    input  logic [DATAW-1:0] sram_rd_data1,

    output logic             sram_rd_en2,
    output logic [ADDRW-1:0] sram_rd_addr2,
    input  logic [DATAW-1:0] sram_rd_data2,

    output logic             sram_wr_en,
    output logic [ADDRW-1:0] sram_wr_addr,
    output logic [DATAW-1:0] sram_wr_data
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    logic [0:0]       state;
    logic [ADDRW-1:0] clr_cnt;

    logic             fwd1;
    logic             fwd2;
    logic [DATAW-1:0] fwd_data1;
    logic [DATAW-1:0] fwd_data2;

    logic             accept;
    logic             wr_acc;
    logic             hit1;
    logic             hit2;

    // Status is a pure function of state so no input can reach busy/ready.
    always_comb begin
        busy   = (state == ST_CLEAR);
        ready  = ~busy;
        accept = (state == ST_IDLE);
    end

    // SRAM pin drive: the clear sweep owns the write port while busy.
    always_comb begin
        wr_acc        = accept & wr_req;
        sram_rd_en1   = accept & rd_req1;
        sram_rd_addr1 = rd_addr1;
        sram_rd_en2   = accept & rd_req2;
        sram_rd_addr2 = rd_addr2;
        if (busy) begin
            sram_wr_en   = 1'b1;
            sram_wr_addr = clr_cnt;
            sram_wr_data = CLRVAL;
        end else begin
            sram_wr_en   = wr_req;
            sram_wr_addr = wr_addr;
            sram_wr_data = wr_data;
        end
    end

    // Read/write collision detection for the forwarding path.
    always_comb begin
        hit1 = sram_rd_en1 & wr_acc & (rd_addr1 == wr_addr);
        hit2 = sram_rd_en2 & wr_acc & (rd_addr2 == wr_addr);
    end

    // Clear-sweep FSM and sweep address counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (flush_req) begin
                        state <= ST_CLEAR;
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

    // One-cycle read valid pipeline plus captured forwarding data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid1 <= 1'b0;
            rd_valid2 <= 1'b0;
            fwd1      <= 1'b0;
            fwd2      <= 1'b0;
            fwd_data1 <= '0;
            fwd_data2 <= '0;
        end else begin
            rd_valid1 <= sram_rd_en1;
            rd_valid2 <= sram_rd_en2;
            fwd1      <= hit1;
            fwd2      <= hit2;
            if (hit1) begin
                fwd_data1 <= wr_data;
            end
            if (hit2) begin
                fwd_data2 <= wr_data;
            end
        end
    end

    // Result select: forwarded write data wins over the stale SRAM value.
    always_comb begin
        rd_data1 = fwd1 ? fwd_data1 : sram_rd_data1;
        rd_data2 = fwd2 ? fwd_data2 : sram_rd_data2;
    end

endmodule
